tt_ranbit_collector: RTL and testbench

Receiving end of the serial random-bit stream produced by the TRNG core (ring oscillator XOR LFSR).
- Accepts one qualified bit per strobe and packs bits MSB-first into words.
- Runs an on-line repetition-count health test on the stream.
- Buffers completed words in a small FIFO with a valid/ready read port for downstream consumers (display, key store, host readout).

---
 rtl/tt_ranbit_pkg.sv | 8 +
 rtl/tt_ranbit_collector_if.sv | 29 ++
 rtl/tt_ranbit_fifo.sv | 52 +++++
 rtl/tt_ranbit_collector.sv | 101 ++++++++++
 tb/tb_tt_ranbit_collector.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/tt_ranbit_pkg.sv
// Shared defaults and types for the random-bit collector slice.
package tt_ranbit_pkg;
    localparam int unsigned WORD_W_DEF     = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned REP_LIMIT_DEF  = 8;

    typedef logic [WORD_W_DEF-1:0] ranword_t;
endpackage

// File: rtl/tt_ranbit_collector_if.sv
// Bit-stream input, health status and valid/ready word read port of the collector.
interface tt_ranbit_collector_if
    import tt_ranbit_pkg::*;
#(
    parameter int unsigned WORD_W     = WORD_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

    logic              bit_in;
    logic              bit_valid;
    logic              clear_fail;
    logic              word_ready;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic [LVL_W-1:0]  fill_level;
    logic              health_fail;
    logic              overflow;

    modport master (
        output bit_in, bit_valid, clear_fail, word_ready,
        input  word_out, word_valid, fill_level, health_fail, overflow
    );

    modport slave (
        input  bit_in, bit_valid, clear_fail, word_ready,
        output word_out, word_valid, fill_level, health_fail, overflow
    );
endinterface

// File: rtl/tt_ranbit_fifo.sv
// Synchronous FIFO with exact occupancy count; a push while full is accepted only alongside a pop.
module tt_ranbit_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             wdata_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        empty_o  = (count_q == '0);
        full_o   = (count_q == CW'(DEPTH));
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) count_d = count_q + CW'(1);
        if (do_pop && !do_push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/tt_ranbit_collector.sv
// Packs qualified random bits MSB-first into words, runs a repetition-count
// health test on the stream and buffers finished words in a small FIFO.
module tt_ranbit_collector
    import tt_ranbit_pkg::*;
#(
    parameter int unsigned WORD_W     = WORD_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned REP_LIMIT  = REP_LIMIT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    tt_ranbit_collector_if.slave bus
);
    localparam int unsigned BW = $clog2(WORD_W);
    localparam int unsigned RW = $clog2(REP_LIMIT + 1);

    // Only the low WORD_W-1 bits are ever kept; the final bit goes straight to the FIFO.
    logic [WORD_W-2:0] sreg_q, sreg_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [RW-1:0]     run_q, run_d, run_next;
    logic              last_q, last_d;
    logic              fail_q, fail_d;
    logic              ovf_q, ovf_d;
    logic [WORD_W-1:0] push_word;
    logic              accept, trip, push, full, empty;

    always_comb begin
        accept    = bus.bit_valid && !fail_q && !bus.clear_fail;
        push_word = {sreg_q, bus.bit_in};
        run_next  = (run_q == '0 || bus.bit_in != last_q) ? RW'(1) : run_q + RW'(1);
        trip      = accept && (run_next == RW'(REP_LIMIT));
        push      = accept && !trip && (bit_cnt_q == BW'(WORD_W - 1));

        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        run_d     = run_q;
        last_d    = last_q;
        fail_d    = fail_q;
        ovf_d     = ovf_q;

        if (bus.clear_fail) begin
            bit_cnt_d = '0;
            run_d     = '0;
            fail_d    = 1'b0;
            ovf_d     = 1'b0;
        end else begin
            if (accept) begin
                sreg_d = push_word[WORD_W-2:0];
                last_d = bus.bit_in;
                run_d  = run_next;
                if (trip) begin
                    fail_d    = 1'b1;
                    bit_cnt_d = '0;
                end else if (bit_cnt_q == BW'(WORD_W - 1)) begin
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            // A simultaneous pop frees a slot, so only a push into a full, non-draining FIFO is lost.
            if (push && full && !(bus.word_ready && !empty)) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            run_q     <= '0;
            last_q    <= 1'b0;
            fail_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            run_q     <= run_d;
            last_q    <= last_d;
            fail_q    <= fail_d;
            ovf_q     <= ovf_d;
        end
    end

    tt_ranbit_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (bus.word_ready),
        .wdata_i (push_word),
        .rdata_o (bus.word_out),
        .full_o  (full),
        .empty_o (empty),
        .count_o (bus.fill_level)
    );

    assign bus.word_valid  = !empty;
    assign bus.health_fail = fail_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_tt_ranbit_collector.sv
// Directed bench for tt_ranbit_collector: packing, FIFO, health test, clear and reset.
module tb_tt_ranbit_collector;
    import tt_ranbit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    tt_ranbit_collector_if #(.WORD_W(8), .FIFO_DEPTH(4)) bus ();

    tt_ranbit_collector #(
        .WORD_W     (8),
        .FIFO_DEPTH (4),
        .REP_LIMIT  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic send_bit(input logic b);
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        @(posedge clk); #1;
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_word(input ranword_t w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic pulse_clear();
        bus.clear_fail = 1'b1;
        @(posedge clk); #1;
        bus.clear_fail = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++; if (bus.word_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", bus.word_valid); else passed++;
        total++; if (bus.fill_level !== 3'd0) $display("FAIL rst_fill: got %0d exp 0", bus.fill_level); else passed++;
        total++; if (bus.word_out !== 8'h00) $display("FAIL rst_word: got %h exp 00", bus.word_out); else passed++;
        total++; if (bus.health_fail !== 1'b0 || bus.overflow !== 1'b0)
            $display("FAIL rst_flags: got hf=%b ov=%b exp 0 0", bus.health_fail, bus.overflow); else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.word_valid !== 1'b0) $display("FAIL post_rst_valid: got %b exp 0", bus.word_valid); else passed++;
    endtask

    task automatic test_pack();
        ranword_t w;
        w = 8'hAA;
        bus.word_ready = 1'b1;
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        total++; if (bus.word_valid !== 1'b0) $display("FAIL pack_early_valid: got %b exp 0", bus.word_valid); else passed++;
        send_bit(w[0]);
        total++; if (bus.word_valid !== 1'b1) $display("FAIL pack_valid: got %b exp 1", bus.word_valid); else passed++;
        total++; if (bus.word_out !== 8'hAA) $display("FAIL pack_word: got %h exp aa", bus.word_out); else passed++;
        @(posedge clk); #1;
        total++; if (bus.fill_level !== 3'd0) $display("FAIL pack_drain: got %0d exp 0", bus.fill_level); else passed++;
        bus.word_ready = 1'b0;
    endtask

    task automatic test_overflow();
        ranword_t exp_w [4];
        exp_w[0] = 8'hAA; exp_w[1] = 8'hCC; exp_w[2] = 8'h5A; exp_w[3] = 8'h33;
        bus.word_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_word(exp_w[i]);
        total++; if (bus.fill_level !== 3'd4 || bus.overflow !== 1'b0)
            $display("FAIL ovf_full: got fill=%0d ov=%b exp 4 0", bus.fill_level, bus.overflow); else passed++;
        send_word(8'h96);
        total++; if (bus.fill_level !== 3'd4 || bus.overflow !== 1'b1)
            $display("FAIL ovf_drop: got fill=%0d ov=%b exp 4 1", bus.fill_level, bus.overflow); else passed++;
        bus.word_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.word_out !== exp_w[i]) $display("FAIL ovf_order%0d: got %h exp %h", i, bus.word_out, exp_w[i]); else passed++;
            @(posedge clk); #1;
        end
        bus.word_ready = 1'b0;
        total++; if (bus.word_valid !== 1'b0) $display("FAIL ovf_empty: got %b exp 0", bus.word_valid); else passed++;
        pulse_clear();
        total++; if (bus.overflow !== 1'b0) $display("FAIL ovf_clear: got %b exp 0", bus.overflow); else passed++;
    endtask

    task automatic test_health();
        bus.word_ready = 1'b0;
        send_word(8'hA0);
        total++; if (bus.fill_level !== 3'd1 || bus.health_fail !== 1'b0)
            $display("FAIL hl_a0: got fill=%0d hf=%b exp 1 0", bus.fill_level, bus.health_fail); else passed++;
        send_bit(1'b0); send_bit(1'b0);
        total++; if (bus.health_fail !== 1'b0) $display("FAIL hl_run7: got %b exp 0", bus.health_fail); else passed++;
        send_bit(1'b0);
        total++; if (bus.health_fail !== 1'b1) $display("FAIL hl_run8: got %b exp 1", bus.health_fail); else passed++;
        send_word(8'h55);
        total++; if (bus.fill_level !== 3'd1 || bus.health_fail !== 1'b1)
            $display("FAIL hl_ignore: got fill=%0d hf=%b exp 1 1", bus.fill_level, bus.health_fail); else passed++;
        pulse_clear();
        total++; if (bus.health_fail !== 1'b0) $display("FAIL hl_clear: got %b exp 0", bus.health_fail); else passed++;
        send_word(8'h00);
        total++; if (bus.fill_level !== 3'd1 || bus.health_fail !== 1'b1)
            $display("FAIL hl_final_bit: got fill=%0d hf=%b exp 1 1", bus.fill_level, bus.health_fail); else passed++;
        pulse_clear();
        bus.word_ready = 1'b1;
        total++; if (bus.word_out !== 8'hA0) $display("FAIL hl_head: got %h exp a0", bus.word_out); else passed++;
        @(posedge clk); #1;
        send_word(8'hAA);
        total++; if (bus.word_out !== 8'hAA || bus.word_valid !== 1'b1)
            $display("FAIL hl_resume: got %h v=%b exp aa 1", bus.word_out, bus.word_valid); else passed++;
        @(posedge clk); #1;
        bus.word_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        ranword_t exp_w [4];
        ranword_t w;
        exp_w[0] = 8'hCC; exp_w[1] = 8'h5A; exp_w[2] = 8'h33; exp_w[3] = 8'h96;
        w = 8'h96;
        bus.word_ready = 1'b0;
        send_word(8'hAA); send_word(8'hCC); send_word(8'h5A); send_word(8'h33);
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        bus.word_ready = 1'b1;
        send_bit(w[0]);
        bus.word_ready = 1'b0;
        total++; if (bus.fill_level !== 3'd4 || bus.overflow !== 1'b0)
            $display("FAIL b2b_full: got fill=%0d ov=%b exp 4 0", bus.fill_level, bus.overflow); else passed++;
        bus.word_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.word_out !== exp_w[i]) $display("FAIL b2b_order%0d: got %h exp %h", i, bus.word_out, exp_w[i]); else passed++;
            @(posedge clk); #1;
        end
        bus.word_ready = 1'b0;
        total++; if (bus.fill_level !== 3'd0) $display("FAIL b2b_empty: got %0d exp 0", bus.fill_level); else passed++;
    endtask

    task automatic test_async_reset();
        bus.word_ready = 1'b0;
        send_word(8'hAA); send_word(8'hCC);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        total++; if (bus.fill_level !== 3'd2 || bus.word_out !== 8'hAA)
            $display("FAIL ar_pre: got fill=%0d word=%h exp 2 aa", bus.fill_level, bus.word_out); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (bus.word_valid !== 1'b0 || bus.fill_level !== 3'd0 || bus.word_out !== 8'h00)
            $display("FAIL ar_clear: got v=%b fill=%0d word=%h exp 0 0 00", bus.word_valid, bus.fill_level, bus.word_out); else passed++;
        total++; if (bus.health_fail !== 1'b0 || bus.overflow !== 1'b0)
            $display("FAIL ar_flags: got hf=%b ov=%b exp 0 0", bus.health_fail, bus.overflow); else passed++;
        @(negedge clk);
        rst = 1'b0;
        send_word(8'h3C);
        total++; if (bus.fill_level !== 3'd1 || bus.word_out !== 8'h3C)
            $display("FAIL ar_after: got fill=%0d word=%h exp 1 3c", bus.fill_level, bus.word_out); else passed++;
        bus.word_ready = 1'b1;
        @(posedge clk); #1;
        bus.word_ready = 1'b0;
    endtask

    task automatic test_clear_coincident();
        ranword_t w;
        w = 8'h69;
        bus.word_ready = 1'b0;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        bus.bit_in     = 1'b0;
        bus.bit_valid  = 1'b1;
        bus.clear_fail = 1'b1;
        @(posedge clk); #1;
        bus.bit_valid  = 1'b0;
        bus.clear_fail = 1'b0;
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        total++; if (bus.fill_level !== 3'd0) $display("FAIL cc_early: got fill=%0d exp 0", bus.fill_level); else passed++;
        send_bit(w[0]);
        total++; if (bus.fill_level !== 3'd1 || bus.word_out !== 8'h69)
            $display("FAIL cc_word: got fill=%0d word=%h exp 1 69", bus.fill_level, bus.word_out); else passed++;
    endtask

    initial begin
        bus.bit_in     = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.clear_fail = 1'b0;
        bus.word_ready = 1'b0;
        test_reset();
        test_pack();
        test_overflow();
        test_health();
        test_back_to_back();
        test_async_reset();
        test_clear_coincident();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1);
    end
endmodule
